// File: rtl/core_pipe_ctrl.sv
// core_pipe_ctrl: hold/flush/redirect sequencer for the IF->ID->EX pipeline with halt handshake
//   in : clk, rst (async, active-low), id_rs1_addr, id_rs2_addr, ex_load, ex_reg_we, ex_rd,
//        ex_jump, ex_jump_addr, ex_busy, halt_req
//   out: halt_ack, hold_pc, pc_load, pc_load_addr, hold_if_id, flush_if_id,
//        hold_id_ex, flush_id_ex, state_out
module core_pipe_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int LOAD_STALL   = 1,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  ex_load,
  input  logic                  ex_reg_we,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_jump,
  input  logic [ADDR_WIDTH-1:0] ex_jump_addr,
  input  logic                  ex_busy,
  input  logic                  halt_req,
  output logic                  halt_ack,
  output logic                  hold_pc,
  output logic                  pc_load,
  output logic [ADDR_WIDTH-1:0] pc_load_addr,
  output logic                  hold_if_id,
  output logic                  flush_if_id,
  output logic                  hold_id_ex,
  output logic                  flush_id_ex,
  output logic [2:0]            state_out
);
  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_STALL   = 3'd1,
    S_FLUSH   = 3'd2,
    S_WAIT_EX = 3'd3,
    S_DRAIN   = 3'd4,
    S_HALTED  = 3'd5
  } state_t;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lu_hz, run_eval, last;
  assign lu_hz = ex_load & ex_reg_we & (ex_rd != '0) &
                 ((ex_rd == id_rs1_addr) | (ex_rd == id_rs2_addr));
  // Full RUN priority evaluation applies in RUN and in the cycle WAIT_EX sees busy drop;
  // STALL and FLUSH only borrow its jump branch.
  assign run_eval = (state_q == S_RUN) | (state_q == S_WAIT_EX & ~ex_busy) |
                    ((state_q == S_STALL | state_q == S_FLUSH) & ex_jump);
  assign last = cnt_q <= 4'd1;
  assign state_out = state_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    halt_ack     = 1'b0;
    hold_pc      = 1'b0;
    pc_load      = 1'b0;
    pc_load_addr = '0;
    hold_if_id   = 1'b0;
    flush_if_id  = 1'b0;
    hold_id_ex   = 1'b0;
    flush_id_ex  = 1'b0;
    if (run_eval) begin
      if (ex_jump) begin
        pc_load      = 1'b1;
        pc_load_addr = ex_jump_addr;
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        state_d      = FLUSH_CYCLES > 1 ? S_FLUSH : S_RUN;
        cnt_d        = FLUSH_CYCLES > 1 ? 4'(FLUSH_CYCLES - 1) : cnt_q;
      end else if (ex_busy) begin
        hold_pc    = 1'b1;
        hold_if_id = 1'b1;
        hold_id_ex = 1'b1;
        state_d    = S_WAIT_EX;
      end else if (lu_hz) begin
        hold_pc     = 1'b1;
        hold_if_id  = 1'b1;
        flush_id_ex = 1'b1;
        state_d     = LOAD_STALL > 1 ? S_STALL : S_RUN;
        cnt_d       = LOAD_STALL > 1 ? 4'(LOAD_STALL - 1) : cnt_q;
      end else if (halt_req) begin
        hold_pc     = 1'b1;
        flush_if_id = 1'b1;
        state_d     = S_DRAIN;
        cnt_d       = 4'(DRAIN_CYCLES);
      end else begin
        state_d = S_RUN;
      end
    end else begin
      case (state_q)
        S_STALL: begin
          hold_pc     = 1'b1;
          hold_if_id  = 1'b1;
          flush_id_ex = 1'b1;
          state_d     = last ? S_RUN : S_STALL;
          cnt_d       = last ? cnt_q : cnt_q - 4'd1;
        end
        S_FLUSH: begin
          flush_if_id = 1'b1;
          state_d     = last ? S_RUN : S_FLUSH;
          cnt_d       = last ? cnt_q : cnt_q - 4'd1;
        end
        S_WAIT_EX: begin
          hold_pc    = 1'b1;
          hold_if_id = 1'b1;
          hold_id_ex = 1'b1;
        end
        S_DRAIN: begin
          hold_pc      = 1'b1;
          flush_if_id  = 1'b1;
          hold_id_ex   = ex_busy;
          pc_load      = ex_jump;
          pc_load_addr = ex_jump ? ex_jump_addr : '0;
          flush_id_ex  = ex_jump;
          // a busy EX freezes the drain count until the op retires
          state_d      = (~ex_busy & last) ? S_HALTED : S_DRAIN;
          cnt_d        = (ex_busy | last) ? cnt_q : cnt_q - 4'd1;
        end
        S_HALTED: begin
          halt_ack    = 1'b1;
          hold_pc     = 1'b1;
          flush_if_id = 1'b1;
          state_d     = halt_req ? S_HALTED : S_RUN;
        end
        default: state_d = S_RUN;
      endcase
    end
    // outputs must read 0 the instant reset asserts, regardless of inputs
    if (!rst) begin
      halt_ack     = 1'b0;
      hold_pc      = 1'b0;
      pc_load      = 1'b0;
      pc_load_addr = '0;
      hold_if_id   = 1'b0;
      flush_if_id  = 1'b0;
      hold_id_ex   = 1'b0;
      flush_id_ex  = 1'b0;
    end
  end
endmodule

// File: tb/tb_core_pipe_ctrl.sv
// tb_core_pipe_ctrl: directed checks of core_pipe_ctrl with default parameters
module tb_core_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd;
  logic        ex_load, ex_reg_we, ex_jump, ex_busy, halt_req;
  logic [31:0] ex_jump_addr, pc_load_addr;
  logic        halt_ack, hold_pc, pc_load, hold_if_id, flush_if_id, hold_id_ex, flush_id_ex;
  logic [2:0]  state_out;
  logic [6:0]  outs;
  int          total = 0;
  int          bad = 0;
  core_pipe_ctrl dut (
    .clk(clk), .rst(rst), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .ex_load(ex_load), .ex_reg_we(ex_reg_we), .ex_rd(ex_rd), .ex_jump(ex_jump),
    .ex_jump_addr(ex_jump_addr), .ex_busy(ex_busy), .halt_req(halt_req),
    .halt_ack(halt_ack), .hold_pc(hold_pc), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
    .hold_if_id(hold_if_id), .flush_if_id(flush_if_id), .hold_id_ex(hold_id_ex),
    .flush_id_ex(flush_id_ex), .state_out(state_out)
  );
  always #5 clk = ~clk;
  assign outs = {halt_ack, hold_pc, pc_load, hold_if_id, flush_if_id, hold_id_ex, flush_id_ex};
  task automatic chk(input string tag, input logic [41:0] got, input logic [41:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic idle();
    {id_rs1_addr, id_rs2_addr, ex_rd} = '0;
    {ex_load, ex_reg_we, ex_jump, ex_busy, halt_req} = '0;
    ex_jump_addr = '0;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  // observed = {state, halt_ack,hold_pc,pc_load,hold_if_id,flush_if_id,hold_id_ex,flush_id_ex, addr}
  task automatic see(input string tag, input logic [2:0] st, input logic [6:0] o, input logic [31:0] a);
    #1;
    chk(tag, {state_out, outs, pc_load_addr}, {st, o, a});
  endtask
  initial begin
    idle();
    ex_jump = 1'b1;
    ex_jump_addr = 32'h55;
    see("rst_idle", 3'd0, 7'b0000000, 32'h0);
    idle();
    #9 rst = 1'b1;
    cyc();
    ex_load = 1; ex_reg_we = 1; ex_rd = 5; id_rs2_addr = 5;
    see("lu_rs2", 3'd0, 7'b0101001, 32'h0);
    cyc();
    id_rs2_addr = 0;
    see("lu_done", 3'd0, 7'b0000000, 32'h0);
    cyc();
    ex_rd = 0; id_rs2_addr = 5;
    see("lu_x0", 3'd0, 7'b0000000, 32'h0);
    cyc();
    ex_rd = 7; id_rs1_addr = 7; id_rs2_addr = 0;
    see("lu_rs1", 3'd0, 7'b0101001, 32'h0);
    cyc();
    ex_reg_we = 0;
    see("lu_nowe", 3'd0, 7'b0000000, 32'h0);
    cyc();
    idle();
    ex_jump = 1; ex_jump_addr = 32'h100;
    see("jmp_c0", 3'd0, 7'b0010101, 32'h100);
    cyc();
    ex_jump = 0;
    see("jmp_c1", 3'd2, 7'b0000100, 32'h0);
    cyc();
    see("jmp_c2", 3'd0, 7'b0000000, 32'h0);
    ex_busy = 1; ex_load = 1; ex_reg_we = 1; ex_rd = 3; id_rs1_addr = 3;
    see("busy_c0", 3'd0, 7'b0101010, 32'h0);
    cyc();
    ex_jump = 1; ex_jump_addr = 32'h80;
    see("busy_jmp_ign", 3'd3, 7'b0101010, 32'h0);
    cyc();
    ex_jump = 0;
    see("busy_c2", 3'd3, 7'b0101010, 32'h0);
    cyc();
    ex_busy = 0;
    see("busy_end_lu", 3'd3, 7'b0101001, 32'h0);
    cyc();
    idle();
    see("busy_back", 3'd0, 7'b0000000, 32'h0);
    halt_req = 1;
    see("halt_req", 3'd0, 7'b0100100, 32'h0);
    cyc();
    ex_jump = 1; ex_jump_addr = 32'h200;
    see("drain_jmp", 3'd4, 7'b0110101, 32'h200);
    cyc();
    ex_jump = 0;
    see("drain_c2", 3'd4, 7'b0100100, 32'h0);
    cyc();
    see("halted", 3'd5, 7'b1100100, 32'h0);
    cyc();
    see("halted_hold", 3'd5, 7'b1100100, 32'h0);
    halt_req = 0;
    see("halted_rel", 3'd5, 7'b1100100, 32'h0);
    cyc();
    see("resumed", 3'd0, 7'b0000000, 32'h0);
    halt_req = 1;
    cyc();
    ex_busy = 1; halt_req = 0;
    see("drain_busy", 3'd4, 7'b0100110, 32'h0);
    cyc();
    ex_busy = 0;
    see("drain_frz1", 3'd4, 7'b0100100, 32'h0);
    cyc();
    see("drain_frz2", 3'd4, 7'b0100100, 32'h0);
    cyc();
    see("halted2", 3'd5, 7'b1100100, 32'h0);
    cyc();
    see("resumed2", 3'd0, 7'b0000000, 32'h0);
    ex_jump = 1; ex_jump_addr = 32'h240;
    cyc();
    ex_jump_addr = 32'h300;
    see("flush_rejmp", 3'd2, 7'b0010101, 32'h300);
    cyc();
    ex_jump = 0;
    see("flush_reload", 3'd2, 7'b0000100, 32'h0);
    cyc();
    see("flush_done", 3'd0, 7'b0000000, 32'h0);
    ex_jump = 1; ex_jump_addr = 32'h400;
    cyc();
    ex_jump = 0;
    see("pre_rst_flush", 3'd2, 7'b0000100, 32'h0);
    rst = 0;
    see("rst_async", 3'd0, 7'b0000000, 32'h0);
    cyc();
    #3 rst = 1;
    cyc();
    see("post_rst_idle", 3'd0, 7'b0000000, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
